// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - E-stage multiply/divide unit with HI/LO register pair
// Result is computed at accept and parked in temp_hi/temp_lo; HI/LO commit when the busy countdown expires.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  input  logic        Req,
  input  logic [31:0] E_V1_f,
  input  logic [31:0] E_V2_f,
  output logic        busy,
  output logic [31:0] MDU_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;

  logic        acc;
  logic [63:0] op_a_ext, op_b_ext, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // One 64-bit multiplier covers both flavours: sign-extend only for mult.
  always_comb begin
    op_a_ext = {{32{(MDU_op == OP_MULT) & E_V1_f[31]}}, E_V1_f};
    op_b_ext = {{32{(MDU_op == OP_MULT) & E_V2_f[31]}}, E_V2_f};
    product  = op_a_ext * op_b_ext;
  end

  // Signed divide via magnitudes; 0x80000000 has magnitude 2^31, so the overflow case falls out naturally.
  always_comb begin
    a_neg = (MDU_op == OP_DIV) & E_V1_f[31];
    b_neg = (MDU_op == OP_DIV) & E_V2_f[31];
    a_mag = a_neg ? (32'd0 - E_V1_f) : E_V1_f;
    b_mag = b_neg ? (32'd0 - E_V2_f) : E_V2_f;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  assign acc = start & ~Req & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    commit_d  = commit_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          case (MDU_op)
            OP_MULT, OP_MULTU: begin
              temp_hi_d = product[63:32];
              temp_lo_d = product[31:0];
              cnt_d     = 4'(MULT_CYCLES - 1);
              commit_d  = 1'b1;
              state_d   = BUSY;
              busy_d    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              temp_hi_d = rem;
              temp_lo_d = quot;
              cnt_d     = 4'(DIV_CYCLES - 1);
              commit_d  = |E_V2_f;
              state_d   = BUSY;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = E_V1_f;
            OP_MTLO: lo_d = E_V1_f;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (commit_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      commit_q  <= commit_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
    end
  end

  assign busy    = busy_q;
  assign MDU_out = (MDU_op == OP_MFHI) ? hi_q :
                   (MDU_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo
// Directed vector table, hand sequences for multi-cycle corners, then random ops against a reference model.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  MDU_op = 4'd0;
  logic        start = 1'b0;
  logic        Req = 1'b0;
  logic [31:0] E_V1_f = 32'd0;
  logic [31:0] E_V2_f = 32'd0;
  logic        busy;
  logic [31:0] MDU_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_op(MDU_op), .start(start), .Req(Req),
    .E_V1_f(E_V1_f), .E_V2_f(E_V2_f), .busy(busy), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        req;
    int          busy_cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: whole 64-bit arithmetic straight from the instruction definitions.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic req);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    if (req) return;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd3: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int model_busy(input logic [3:0] op, input logic req);
    if (req) return 0;
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Issues one op for one cycle, then counts busy cycles (bounded); optionally holds Req during busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic req_busy, output int cyc);
    @(negedge clk);
    MDU_op = op; E_V1_f = a; E_V2_f = b; start = 1'b1; Req = req;
    @(negedge clk);
    start = 1'b0; MDU_op = 4'd0; Req = req_busy;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    Req = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    MDU_op = 4'd5; #1 h = MDU_out;
    MDU_op = 4'd6; #1 l = MDU_out;
    MDU_op = 4'd0;
  endtask

  initial begin
    logic [31:0] h, l;
    int cyc;
    logic [3:0] op;
    logic [31:0] a, b;
    logic rq;

    tbl[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1] = '{4'd2, 32'hFFFFFFFD, 32'd5,        1'b0, 5,  32'h00000004, 32'hFFFFFFF1};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd4, 32'd7,        32'd2,        1'b0, 10, 32'h00000001, 32'h00000003};
    tbl[4] = '{4'd7, 32'h12345678, 32'd0,        1'b0, 0,  32'h12345678, 32'h00000003};
    tbl[5] = '{4'd4, 32'd5,        32'd0,        1'b0, 10, 32'h12345678, 32'h00000003};
    tbl[6] = '{4'd1, 32'd3,        32'd4,        1'b1, 0,  32'h12345678, 32'h00000003};
    tbl[7] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    tbl[8] = '{4'd8, 32'hCAFEF00D, 32'd0,        1'b0, 0,  32'h00000000, 32'hCAFEF00D};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    read_hilo(h, l);
    chk("reset_hi", h, 32'd0);
    chk("reset_lo", l, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].req, 1'b0, cyc);
      model_apply(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].req);
      chk($sformatf("vec%0d_busy", i), 32'(cyc), 32'(tbl[i].busy_cyc));
      read_hilo(h, l);
      chk($sformatf("vec%0d_hi", i), h, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), l, tbl[i].lo);
    end

    // Req held high across a div's busy window must not stop the commit.
    run_op(4'd3, 32'd100, 32'd7, 1'b0, 1'b1, cyc);
    model_apply(4'd3, 32'd100, 32'd7, 1'b0);
    chk("reqbusy_busy", 32'(cyc), 32'd10);
    read_hilo(h, l);
    chk("reqbusy_hi", h, 32'd2);
    chk("reqbusy_lo", l, 32'd14);

    // mtlo issued while busy is ignored; the mult result lands.
    @(negedge clk);
    MDU_op = 4'd1; E_V1_f = 32'd2; E_V2_f = 32'd3; start = 1'b1;
    @(negedge clk);
    MDU_op = 4'd8; E_V1_f = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDU_op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    model_apply(4'd1, 32'd2, 32'd3, 1'b0);
    read_hilo(h, l);
    chk("mtlo_busy_hi", h, 32'd0);
    chk("mtlo_busy_lo", l, 32'd6);

    // Start on the completion edge is ignored.
    @(negedge clk);
    MDU_op = 4'd2; E_V1_f = 32'h00010000; E_V2_f = 32'h00010000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDU_op = 4'd0;
    repeat (4) @(negedge clk);
    chk("cmpl_busy_last", 32'(busy), 32'd1);
    MDU_op = 4'd7; E_V1_f = 32'h55555555; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDU_op = 4'd0;
    chk("cmpl_busy_done", 32'(busy), 32'd0);
    model_apply(4'd2, 32'h00010000, 32'h00010000, 1'b0);
    read_hilo(h, l);
    chk("cmpl_hi", h, 32'd1);
    chk("cmpl_lo", l, 32'd0);

    // Reset mid-mult: mtlo during busy ignored, mult never commits.
    @(negedge clk);
    MDU_op = 4'd1; E_V1_f = 32'd9; E_V2_f = 32'd9; start = 1'b1;
    @(negedge clk);
    MDU_op = 4'd8; E_V1_f = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0; MDU_op = 4'd0;
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (8) @(negedge clk);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);
    read_hilo(h, l);
    chk("rst_mid_hi", h, 32'd0);
    chk("rst_mid_lo", l, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      if ($urandom_range(0, 9) == 0) b = 32'hFFFFFFFF;
      rq = ($urandom_range(0, 7) == 0);
      run_op(op, a, b, rq, 1'b0, cyc);
      model_apply(op, a, b, rq);
      chk($sformatf("rnd%0d_op%0d_busy", i, op), 32'(cyc), 32'(model_busy(op, rq)));
      read_hilo(h, l);
      chk($sformatf("rnd%0d_op%0d_hi", i, op), h, hi_m);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), l, lo_m);
    end

    MDU_op = 4'd0; #1;
    chk("mdu_out_none", MDU_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit of the E stage, with its HI/LO register pair.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Presents the HI/LO read value on MDU_out, which the E-stage ALU/MDU result select consumes.
- Drives busy to the hazard unit; that unit stalls any MDU-class instruction in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- MDU_op  input  4  operation code:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9-15 treated as none.
- start  input  1  E-stage instruction valid for MDU_op.
- Req  input  1  exception/interrupt taken this cycle; squashes the E-stage instruction.
- E_V1_f  input  32  forwarded rs operand.
- E_V2_f  input  32  forwarded rt operand.
- busy  output  1  registered; high while a mult/div is in flight.
- MDU_out  output  32  HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset:
  - Asynchronous, active when reset==0.
  - HI=0, LO=0, counter=0, state IDLE, busy=0.
  - Any in-flight operation is discarded without updating HI/LO.
- Accept condition, defined as acc = start & ~Req & (state==IDLE).
- States:
  - IDLE -> BUSY on a rising edge with acc and MDU_op in 1..4.
  - BUSY -> IDLE on the edge where the counter reaches 0.
  - No other transitions.
- On accept of mult/div (MDU_op 1..4), at that edge:
  - Compute the 64-bit result from E_V1_f/E_V2_f and hold it in internal temp_hi/temp_lo.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy goes high from the next cycle.
- In BUSY:
  - The counter decrements each edge.
  - On the edge where the counter equals 0: HI<=temp_hi, LO<=temp_lo, busy<=0.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - New HI/LO values are visible in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - multu: unsigned 32x32 -> 64, same HI/LO split.
  - div/divu: LO = quotient, HI = remainder.
  - div: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): the full busy sequence still runs, and HI/LO keep their previous values at completion.
- mthi/mtlo:
  - Write on the accept edge: HI<=E_V1_f or LO<=E_V1_f.
  - Write only when acc; not accepted while busy, since acc requires IDLE.
  - No busy period.
- mfhi/mflo:
  - MDU_out is combinational: HI or LO of the current register state, independent of start/Req.
  - When busy, the registers still hold the old values; the hazard unit stalls, so none is read.
- Req:
  - Req in the start cycle suppresses everything: no state change, no HI/LO write, busy stays 0.
  - Req during BUSY has no effect; the accepted operation completes and commits.
- start with a mult/div/mt op while in BUSY is ignored entirely (hazard-unit error case); it has no side effects.
- Simultaneous completion edge and start: start is ignored on that edge (state is still BUSY).

Test Plan:
- Hold reset low mid-sequence, then release -> busy=0, mfhi and mflo both read 0x00000000.
- mult with rs=0xFFFFFFFD (-3), rt=5 -> busy high for 5 cycles, then mfhi=0xFFFFFFFF, mflo=0xFFFFFFF1; multu on the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with 7/2 -> LO=3, HI=1.
- mthi 0x12345678 then divu rs=5, rt=0 -> busy high for 10 cycles, then HI=0x12345678 and LO unchanged.
- mult start with Req=1 -> busy stays 0 and HI/LO are unchanged; Req=1 asserted during a div's BUSY -> the div still commits.
- Start a mult, assert mtlo with start during BUSY, and pull reset low on cycle 3 -> the mtlo is ignored, and reset gives busy=0 with HI=LO=0, the mult never committed.
